// File: rtl/inst_sequencer_pkg.sv
// Shared constants for the instruction sequencer: instruction layout, opcodes,
// hold lengths and the opcode-to-hold-length lookup.
package inst_sequencer_pkg;

    localparam int OPCODE_W  = 4;
    localparam int ADDR_W    = 8;
    localparam int OPERAND_W = 128;
    localparam int INST_W    = OPCODE_W + 2 * ADDR_W + OPERAND_W;

    localparam int OPCODE_TO    = INST_W - 1;
    localparam int OPCODE_FROM  = INST_W - OPCODE_W;
    localparam int ADDRA_TO     = OPCODE_FROM - 1;
    localparam int ADDRA_FROM   = ADDRA_TO - ADDR_W + 1;
    localparam int ADDRB_TO     = ADDRA_FROM - 1;
    localparam int ADDRB_FROM   = ADDRB_TO - ADDR_W + 1;
    localparam int OPERAND_TO   = OPERAND_W - 1;
    localparam int OPERAND_FROM = 0;

    typedef logic [OPCODE_W-1:0] opcode_t;

    localparam opcode_t IDLE_INST              = 4'd0;
    localparam opcode_t AXI_TO_UB_INST         = 4'd1;
    localparam opcode_t AXI_TO_WB_INST         = 4'd2;
    localparam opcode_t UB_TO_DATA_FIFO_INST   = 4'd3;
    localparam opcode_t UB_TO_WEIGHT_FIFO_INST = 4'd4;
    localparam opcode_t MAT_MUL_INST           = 4'd5;
    localparam opcode_t MAT_MUL_ACC_INST       = 4'd6;
    localparam opcode_t ACC_TO_UB_INST         = 4'd7;

    localparam int MAT_MUL_CYCLE   = 32;
    localparam int ACC_TO_UB_CYCLE = 16;
    localparam int SINGLE_CYCLE    = 1;

    // Wide enough to hold the longest hold length (32).
    localparam int HOLD_W = 6;
    typedef logic [HOLD_W-1:0] hold_t;

    typedef enum logic {
        S_IDLE,
        S_HOLD
    } state_t;

    function automatic hold_t op_cycles(opcode_t op);
        case (op)
            MAT_MUL_INST, MAT_MUL_ACC_INST: return hold_t'(MAT_MUL_CYCLE);
            ACC_TO_UB_INST:                 return hold_t'(ACC_TO_UB_CYCLE);
            default:                        return hold_t'(SINGLE_CYCLE);
        endcase
    endfunction

    function automatic logic op_illegal(opcode_t op);
        return op > ACC_TO_UB_INST;
    endfunction

endpackage

// File: rtl/inst_sequencer_if.sv
// Host push channel and control-unit issue channel of the instruction sequencer.
interface inst_sequencer_if
    import inst_sequencer_pkg::*;
#(
    parameter int INST_BITS = INST_W
) ();

    logic [INST_BITS-1:0] s_inst;
    logic                 s_valid;
    logic                 s_ready;
    logic [INST_BITS-1:0] cu_inst;
    logic                 cu_inst_valid;

    modport master (
        output s_inst,
        output s_valid,
        input  s_ready,
        input  cu_inst,
        input  cu_inst_valid
    );

    modport slave (
        input  s_inst,
        input  s_valid,
        output s_ready,
        output cu_inst,
        output cu_inst_valid
    );

endinterface

// File: rtl/inst_sequencer_fifo.sv
// Synchronous instruction FIFO; pointers carry one extra wrap bit so that
// full and empty are distinguished without an occupancy counter.
module inst_fifo
    import inst_sequencer_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int INST_BITS = INST_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic                 pop,
    input  logic [INST_BITS-1:0] din,
    output logic [INST_BITS-1:0] dout,
    output logic                 full,
    output logic                 empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]          wr_ptr_q;
    logic [AW:0]          rd_ptr_q;
    logic [INST_BITS-1:0] mem_q [DEPTH];
    logic                 do_push;
    logic                 do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // NOTE: storage is not reset; an entry is only visible once the pointers say so.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/inst_sequencer.sv
// Instruction front-end: queues host instructions and presents each one to the
// control unit for exactly the number of cycles its opcode needs.
module inst_sequencer
    import inst_sequencer_pkg::*;
#(
    parameter int OPCODE_BITS  = OPCODE_W,
    parameter int ADDR_BITS    = ADDR_W,
    parameter int OPERAND_BITS = OPERAND_W,
    parameter int DEPTH        = 16,
    parameter int CNT_BITS     = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    input  logic                clear_err,
    inst_sequencer_if.slave     bus,
    output logic                busy,
    output logic [CNT_BITS-1:0] issued_cnt,
    output logic                illegal_op
);

    localparam int INST_BITS = OPCODE_BITS + 2 * ADDR_BITS + OPERAND_BITS;

    state_t               state_q, state_d;
    logic [INST_BITS-1:0] inst_q, inst_d;
    hold_t                hold_q, hold_d;
    logic [CNT_BITS-1:0]  cnt_q, cnt_d;
    logic                 illegal_q, illegal_d;

    logic                 load;
    logic                 push;
    logic [INST_BITS-1:0] fifo_dout;
    logic                 fifo_full;
    logic                 fifo_empty;
    opcode_t              head_op;

    assign bus.s_ready = !fifo_full && !reset;
    assign push        = bus.s_valid && bus.s_ready;
    assign head_op     = fifo_dout[INST_BITS-1 -: OPCODE_BITS];

    inst_fifo #(
        .DEPTH     (DEPTH),
        .INST_BITS (INST_BITS)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (load),
        .din   (bus.s_inst),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // NOTE: every next-state signal takes its hold value first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        inst_d    = inst_q;
        hold_d    = hold_q;
        cnt_d     = cnt_q;
        illegal_d = illegal_q;
        load      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                load = run && !fifo_empty;
            end
            S_HOLD: begin
                if (hold_q != '0) begin
                    hold_d = hold_q - hold_t'(1);
                end else begin
                    // Last cycle of the hold: retire it and chain the next entry without a bubble.
                    cnt_d = cnt_q + CNT_BITS'(1);
                    load  = run && !fifo_empty;
                    if (!load) begin
                        state_d = S_IDLE;
                        inst_d  = '0;
                    end
                end
            end
        endcase

        if (load) begin
            state_d = S_HOLD;
            inst_d  = fifo_dout;
            hold_d  = op_cycles(head_op) - hold_t'(1);
        end

        // A set on the pop edge overrides a simultaneous clear.
        if (clear_err)                       illegal_d = 1'b0;
        if (load && op_illegal(head_op))     illegal_d = 1'b1;
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            inst_q    <= '0;
            hold_q    <= '0;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            inst_q    <= inst_d;
            hold_q    <= hold_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.cu_inst       = inst_q;
    assign bus.cu_inst_valid = (state_q == S_HOLD);
    assign busy              = !fifo_empty || (state_q == S_HOLD);
    assign issued_cnt        = cnt_q;
    assign illegal_op        = illegal_q;

endmodule

// File: tb/tb_inst_sequencer.sv
// Self-checking bench: compares the per-cycle issue stream against a queue of
// expected instructions expanded by their hold lengths.
module tb_inst_sequencer;
    import inst_sequencer_pkg::*;

    typedef logic [INST_W-1:0] inst_vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        clear_err;
    logic        busy;
    logic [15:0] issued_cnt;
    logic        illegal_op;

    inst_sequencer_if bus ();

    inst_sequencer #(
        .DEPTH    (16),
        .CNT_BITS (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .clear_err  (clear_err),
        .bus        (bus.slave),
        .busy       (busy),
        .issued_cnt (issued_cnt),
        .illegal_op (illegal_op)
    );

    always #5 clk = ~clk;

    int        tests_run    = 0;
    int        tests_failed = 0;
    inst_vec_t obs_q[$];
    inst_vec_t exp_q[$];
    bit        mon_en       = 1'b0;
    bit        seen_valid;
    int        gap_cycles;
    int        idle_dirty;
    int        exp_issued   = 0;

    // Monitor samples 2 time units after each edge, after the stimulus tasks act.
    always @(posedge clk) begin
        #2;
        if (mon_en) begin
            if (bus.cu_inst_valid === 1'b1) begin
                obs_q.push_back(bus.cu_inst);
                seen_valid = 1'b1;
            end else begin
                if (seen_valid && busy) gap_cycles++;
                if (bus.cu_inst !== '0) idle_dirty++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic int cycles_of(logic [3:0] op);
        if (op == 4'd5 || op == 4'd6) return 32;
        if (op == 4'd7) return 16;
        return 1;
    endfunction

    function automatic inst_vec_t mk(logic [3:0] op, logic [7:0] addra);
        inst_vec_t v;
        v = '0;
        v[OPCODE_TO:OPCODE_FROM]   = op;
        v[ADDRA_TO:ADDRA_FROM]     = addra;
        v[ADDRB_TO:ADDRB_FROM]     = 8'($urandom);
        v[OPERAND_TO:OPERAND_FROM] = {$urandom, $urandom, $urandom, $urandom};
        return v;
    endfunction

    function automatic int seq_diff();
        int n;
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (obs_q[i] !== exp_q[i]) return i;
        if (obs_q.size() != exp_q.size()) return n;
        return -1;
    endfunction

    task automatic expect_inst(inst_vec_t v);
        repeat (cycles_of(v[OPCODE_TO:OPCODE_FROM])) exp_q.push_back(v);
        exp_issued++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mon_clear();
        obs_q.delete();
        exp_q.delete();
        gap_cycles = 0;
        idle_dirty = 0;
        seen_valid = 1'b0;
        mon_en     = 1'b1;
    endtask

    task automatic push_one(inst_vec_t v);
        int n = 0;
        bus.s_valid = 1'b1;
        bus.s_inst  = v;
        while (bus.s_ready !== 1'b1 && n < 2000) begin
            step();
            n++;
        end
        tests_run++;
        if (n >= 2000) begin
            tests_failed++;
            $display("FAIL push_wait: s_ready stayed %b, want 1 within 2000 cycles", bus.s_ready);
        end
        step();
        bus.s_valid = 1'b0;
        expect_inst(v);
    endtask

    task automatic wait_idle(int budget, string tag);
        int n = 0;
        while ((busy !== 1'b0 || bus.cu_inst_valid !== 1'b0) && n < budget) begin
            step();
            n++;
        end
        tests_run++;
        if (n >= budget) begin
            tests_failed++;
            $display("FAIL %s idle_wait: busy=%b valid=%b after %0d cycles, want 0/0", tag, busy, bus.cu_inst_valid, n);
        end
    endtask

    task automatic test_reset();
        int bad = 0;
        reset = 1'b1; run = 1'b1; clear_err = 1'b0;
        bus.s_valid = 1'b0; bus.s_inst = '0;
        step(); step();
        reset = 1'b0;
        exp_issued = 0;
        mon_clear();
        repeat (20) begin
            step();
            if (bus.cu_inst_valid !== 1'b0 || bus.cu_inst !== '0 || busy !== 1'b0 || bus.s_ready !== 1'b1) bad++;
        end
        tests_run++;
        if (bad !== 0) begin tests_failed++; $display("FAIL reset_idle: %0d bad cycles, want 0", bad); end
        tests_run++;
        if (bus.cu_inst !== '0) begin tests_failed++; $display("FAIL reset_cu_inst: got %h, want 0", bus.cu_inst); end
        tests_run++;
        if (issued_cnt !== 16'd0) begin tests_failed++; $display("FAIL reset_issued: got %0d, want 0", issued_cnt); end
        tests_run++;
        if (illegal_op !== 1'b0) begin tests_failed++; $display("FAIL reset_illegal: got %b, want 0", illegal_op); end
    endtask

    task automatic test_single_matmul();
        inst_vec_t v;
        int d;
        mon_clear();
        v = mk(4'd5, 8'd3);
        bus.s_valid = 1'b1; bus.s_inst = v;
        step();
        bus.s_valid = 1'b0;
        expect_inst(v);
        tests_run++;
        if (bus.cu_inst_valid !== 1'b0) begin tests_failed++; $display("FAIL single_latency1: valid=%b one edge after push, want 0", bus.cu_inst_valid); end
        step();
        tests_run++;
        if (bus.cu_inst_valid !== 1'b1 || bus.cu_inst !== v) begin
            tests_failed++;
            $display("FAIL single_latency2: valid=%b inst=%h two edges after push, want 1 / %h", bus.cu_inst_valid, bus.cu_inst, v);
        end
        wait_idle(200, "single");
        d = seq_diff();
        tests_run++;
        if (d != -1) begin tests_failed++; $display("FAIL single_seq: diff at %0d, got %0d valid cycles, want %0d", d, obs_q.size(), exp_q.size()); end
        tests_run++;
        if (gap_cycles !== 0) begin tests_failed++; $display("FAIL single_gap: got %0d gap cycles, want 0", gap_cycles); end
        tests_run++;
        if (issued_cnt !== 16'(exp_issued)) begin tests_failed++; $display("FAIL single_issued: got %0d, want %0d", issued_cnt, exp_issued); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] ops [4] = '{4'd3, 4'd4, 4'd5, 4'd6};
        int d;
        mon_clear();
        for (int i = 0; i < 4; i++) push_one(mk(ops[i], 8'(10 + i)));
        wait_idle(300, "b2b");
        d = seq_diff();
        tests_run++;
        if (d != -1 || obs_q.size() != 66) begin tests_failed++; $display("FAIL b2b_seq: diff at %0d, got %0d valid cycles, want 66", d, obs_q.size()); end
        tests_run++;
        if (gap_cycles !== 0) begin tests_failed++; $display("FAIL b2b_gap: got %0d gap cycles, want 0", gap_cycles); end
        tests_run++;
        if (idle_dirty !== 0) begin tests_failed++; $display("FAIL b2b_idle_inst: got %0d non-zero idle cycles, want 0", idle_dirty); end
        tests_run++;
        if (issued_cnt !== 16'(exp_issued)) begin tests_failed++; $display("FAIL b2b_issued: got %0d, want %0d", issued_cnt, exp_issued); end
    endtask

    task automatic test_backpressure();
        inst_vec_t acc [16];
        inst_vec_t v;
        int k = 0;
        int n = 0;
        int bad = 0;
        int d;
        run = 1'b0;
        mon_clear();
        bus.s_valid = 1'b1;
        while (k < 16 && n < 100) begin
            v = mk(4'($urandom_range(0, 7)), 8'(k));
            bus.s_inst = v;
            if (bus.s_ready === 1'b1) begin acc[k] = v; k++; end
            step();
            n++;
        end
        tests_run++;
        if (n !== 16) begin tests_failed++; $display("FAIL bp_accept: 16 accepts took %0d cycles, want 16", n); end
        bus.s_inst = mk(4'd1, 8'd16);
        repeat (3) begin
            if (bus.s_ready !== 1'b0 || bus.cu_inst_valid !== 1'b0 || busy !== 1'b1) bad++;
            step();
        end
        tests_run++;
        if (bad !== 0) begin tests_failed++; $display("FAIL bp_full: %0d cycles with s_ready/valid/busy wrong, want 0", bad); end
        bus.s_valid = 1'b0;
        for (int i = 0; i < 16; i++) expect_inst(acc[i]);
        run = 1'b1;
        wait_idle(1000, "bp");
        d = seq_diff();
        tests_run++;
        if (d != -1) begin tests_failed++; $display("FAIL bp_seq: diff at %0d, got %0d valid cycles, want %0d", d, obs_q.size(), exp_q.size()); end
        tests_run++;
        if (obs_q.size() == 0 || obs_q[obs_q.size()-1][ADDRA_TO:ADDRA_FROM] !== 8'd15) begin
            tests_failed++; $display("FAIL bp_last_addra: last issued ADDRA wrong, got %0d valid cycles, want final ADDRA 15", obs_q.size());
        end
        tests_run++;
        if (issued_cnt !== 16'(exp_issued)) begin tests_failed++; $display("FAIL bp_issued: got %0d, want %0d", issued_cnt, exp_issued); end
    endtask

    task automatic test_run_drop();
        inst_vec_t a, b, c;
        int n = 0;
        int d;
        run = 1'b1;
        mon_clear();
        a = mk(4'd5, 8'd1); b = mk(4'd2, 8'd2); c = mk(4'd7, 8'd3);
        push_one(a);
        bus.s_valid = 1'b1; bus.s_inst = b; step();
        bus.s_inst = c; step();
        bus.s_valid = 1'b0;
        while (obs_q.size() < 10 && n < 100) begin step(); n++; end
        run = 1'b0;
        n = 0;
        while (bus.cu_inst_valid === 1'b1 && n < 100) begin step(); n++; end
        repeat (3) step();
        d = seq_diff();
        tests_run++;
        if (d != -1) begin tests_failed++; $display("FAIL drop_hold: diff at %0d, got %0d valid cycles, want %0d", d, obs_q.size(), exp_q.size()); end
        tests_run++;
        if (bus.cu_inst_valid !== 1'b0 || busy !== 1'b1 || bus.cu_inst !== '0) begin
            tests_failed++; $display("FAIL drop_idle: valid=%b busy=%b, want 0/1 with queued entries", bus.cu_inst_valid, busy);
        end
        expect_inst(b);
        expect_inst(c);
        run = 1'b1;
        wait_idle(200, "drop");
        d = seq_diff();
        tests_run++;
        if (d != -1) begin tests_failed++; $display("FAIL drop_resume: diff at %0d, got %0d valid cycles, want %0d", d, obs_q.size(), exp_q.size()); end
        tests_run++;
        if (issued_cnt !== 16'(exp_issued)) begin tests_failed++; $display("FAIL drop_issued: got %0d, want %0d", issued_cnt, exp_issued); end
    endtask

    task automatic test_illegal();
        inst_vec_t v;
        run = 1'b1; clear_err = 1'b0;
        mon_clear();
        v = mk(4'd9, 8'd7);
        push_one(v);
        step();
        tests_run++;
        if (bus.cu_inst_valid !== 1'b1 || bus.cu_inst !== v || illegal_op !== 1'b1) begin
            tests_failed++; $display("FAIL ill_issue: valid=%b illegal=%b inst=%h, want 1/1/%h", bus.cu_inst_valid, illegal_op, bus.cu_inst, v);
        end
        step();
        tests_run++;
        if (bus.cu_inst_valid !== 1'b0 || illegal_op !== 1'b1) begin
            tests_failed++; $display("FAIL ill_sticky: valid=%b illegal=%b, want 0/1", bus.cu_inst_valid, illegal_op);
        end
        clear_err = 1'b1; step(); clear_err = 1'b0;
        tests_run++;
        if (illegal_op !== 1'b0) begin tests_failed++; $display("FAIL ill_clear: got %b, want 0", illegal_op); end
        clear_err = 1'b1;
        push_one(mk(4'd12, 8'd8));
        step();
        tests_run++;
        if (illegal_op !== 1'b1) begin tests_failed++; $display("FAIL ill_set_wins: got %b, want 1", illegal_op); end
        step();
        tests_run++;
        if (illegal_op !== 1'b0) begin tests_failed++; $display("FAIL ill_clear2: got %b, want 0", illegal_op); end
        clear_err = 1'b0;
        wait_idle(50, "ill");
        tests_run++;
        if (issued_cnt !== 16'(exp_issued)) begin tests_failed++; $display("FAIL ill_issued: got %0d, want %0d", issued_cnt, exp_issued); end
    endtask

    task automatic test_reset_mid_hold();
        int n = 0;
        int bad = 0;
        run = 1'b1;
        push_one(mk(4'd13, 8'd0));
        wait_idle(50, "rst_pre");
        mon_clear();
        push_one(mk(4'd6, 8'd1));
        push_one(mk(4'd1, 8'd2));
        push_one(mk(4'd3, 8'd3));
        while (obs_q.size() < 5 && n < 100) begin step(); n++; end
        reset = 1'b1;
        step();
        exp_issued = 0;
        tests_run++;
        if (bus.cu_inst !== '0 || bus.cu_inst_valid !== 1'b0 || busy !== 1'b0) begin
            tests_failed++; $display("FAIL rst_hold_out: valid=%b busy=%b inst=%h, want 0/0/0", bus.cu_inst_valid, busy, bus.cu_inst);
        end
        tests_run++;
        if (issued_cnt !== 16'd0 || illegal_op !== 1'b0) begin
            tests_failed++; $display("FAIL rst_hold_status: issued=%0d illegal=%b, want 0/0", issued_cnt, illegal_op);
        end
        tests_run++;
        if (bus.s_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_ready: got %b during reset, want 0", bus.s_ready); end
        reset = 1'b0;
        step();
        tests_run++;
        if (bus.s_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_ready_after: got %b, want 1", bus.s_ready); end
        repeat (5) begin
            step();
            if (bus.cu_inst_valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        tests_run++;
        if (bad !== 0) begin tests_failed++; $display("FAIL rst_fifo_empty: %0d cycles issuing after reset, want 0", bad); end
    endtask

    task automatic test_random();
        bit exp_ill = 1'b0;
        logic [3:0] op;
        int d;
        run = 1'b1;
        clear_err = 1'b1; step(); clear_err = 1'b0;
        mon_clear();
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 15));
            if (op > 4'd7) exp_ill = 1'b1;
            push_one(mk(op, 8'(i)));
            repeat ($urandom_range(0, 3)) step();
        end
        wait_idle(5000, "rand");
        d = seq_diff();
        tests_run++;
        if (d != -1) begin tests_failed++; $display("FAIL rand_seq: diff at %0d, got %0d valid cycles, want %0d", d, obs_q.size(), exp_q.size()); end
        tests_run++;
        if (issued_cnt !== 16'(exp_issued)) begin tests_failed++; $display("FAIL rand_issued: got %0d, want %0d", issued_cnt, exp_issued); end
        tests_run++;
        if (illegal_op !== exp_ill) begin tests_failed++; $display("FAIL rand_illegal: got %b, want %b", illegal_op, exp_ill); end
        tests_run++;
        if (idle_dirty !== 0) begin tests_failed++; $display("FAIL rand_idle_inst: got %0d non-zero idle cycles, want 0", idle_dirty); end
    endtask

    initial begin
        test_reset();
        test_single_matmul();
        test_back_to_back();
        test_backpressure();
        test_run_drop();
        test_illegal();
        test_reset_mid_hold();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
